// File: rtl/imm_operand_gen.sv
// ID-stage immediate generator with an ID/EX output register and a one-entry skid buffer.
// Optional feature: define IMM_ILLEGAL_FLAG_EN to flag opcodes 0xA-0xF via a sticky illegal_op.
module imm_operand_gen #(
    parameter int unsigned DATA_W = 16
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              flush,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] instr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] imm_ext,
    output logic [2:0]        shamt,
    output logic              imm_sel,
    output logic              illegal_op
);

    localparam int unsigned SHAMT_W = 3;
    localparam int unsigned OPC_W   = 4;

    localparam logic [OPC_W-1:0] OP_RTYPE = 4'h0;
    localparam logic [OPC_W-1:0] OP_ADDI  = 4'h1;
    localparam logic [OPC_W-1:0] OP_ANDI  = 4'h2;
    localparam logic [OPC_W-1:0] OP_ORI   = 4'h3;
    localparam logic [OPC_W-1:0] OP_SLL   = 4'h4;
    localparam logic [OPC_W-1:0] OP_SRL   = 4'h5;
    localparam logic [OPC_W-1:0] OP_LW    = 4'h6;
    localparam logic [OPC_W-1:0] OP_SW    = 4'h7;
    localparam logic [OPC_W-1:0] OP_BEQ   = 4'h8;
    localparam logic [OPC_W-1:0] OP_LUI   = 4'h9;

    typedef struct packed {
        logic [DATA_W-1:0]  imm;
        logic [SHAMT_W-1:0] shamt;
        logic               sel;
    } word_t;

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_t;

    state_t           state;
    word_t            dec;
    logic             dec_ill;
    word_t            out_q;
    word_t            skid_q;
    logic             skid_ill;
    logic [OPC_W-1:0] opcode;
    logic             accept;
    logic             unused_bits;

    assign opcode      = instr[15:12];
    assign unused_bits = ^instr[11:8];
    assign accept      = in_valid && in_ready;

    assign imm_ext = out_q.imm;
    assign shamt   = out_q.shamt;
    assign imm_sel = out_q.sel;

    // Combinational decode of the incoming instruction word
    always_comb begin
        dec       = '0;
        dec.shamt = instr[2:0];
        dec_ill   = 1'b0;
        case (opcode)
            OP_ADDI, OP_LW, OP_SW, OP_BEQ: dec.imm = DATA_W'($signed(instr[5:0]));
            OP_ANDI, OP_ORI:               dec.imm = DATA_W'(instr[5:0]);
            OP_SLL, OP_SRL:                dec.sel = 1'b1;
            OP_LUI:                        dec.imm = DATA_W'({instr[7:0], 8'h00});
            OP_RTYPE:                      dec.imm = '0;
            default: begin
`ifdef IMM_ILLEGAL_FLAG_EN
                dec_ill = 1'b1;
`else
                dec_ill = 1'b0;
`endif
            end
        endcase
    end

    // Handshake FSM; flush outranks every handshake, illegal_op is sticky until flush/reset
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= EMPTY;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            out_q      <= '0;
            skid_q     <= '0;
            skid_ill   <= 1'b0;
            illegal_op <= 1'b0;
        end else if (flush) begin
            state      <= EMPTY;
            out_valid  <= 1'b0;
            in_ready   <= 1'b1;
            illegal_op <= 1'b0;
        end else begin
            case (state)
                EMPTY: begin
                    if (accept) begin
                        out_q      <= dec;
                        illegal_op <= illegal_op | dec_ill;
                        out_valid  <= 1'b1;
                        state      <= FULL;
                    end
                end
                FULL: begin
                    if (accept && out_ready) begin
                        out_q      <= dec;
                        illegal_op <= illegal_op | dec_ill;
                    end else if (accept) begin
                        skid_q   <= dec;
                        skid_ill <= dec_ill;
                        in_ready <= 1'b0;
                        state    <= SKID;
                    end else if (out_ready) begin
                        out_valid <= 1'b0;
                        state     <= EMPTY;
                    end
                end
                SKID: begin
                    if (out_ready) begin
                        out_q      <= skid_q;
                        illegal_op <= illegal_op | skid_ill;
                        in_ready   <= 1'b1;
                        state      <= FULL;
                    end
                end
                default: begin
                    out_valid <= 1'b0;
                    in_ready  <= 1'b1;
                    state     <= EMPTY;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_imm_operand_gen.sv
// Directed bench for imm_operand_gen: expected beats are queued on acceptance and checked on delivery.
module tb_imm_operand_gen;

`ifdef IMM_ILLEGAL_FLAG_EN
    localparam bit ILL_EN = 1'b1;
`else
    localparam bit ILL_EN = 1'b0;
`endif

    typedef struct packed {
        logic [15:0] imm;
        logic [2:0]  sh;
        logic        sel;
        logic        ill;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        flush;
    logic        in_valid;
    logic        in_ready;
    logic [15:0] instr;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] imm_ext;
    logic [2:0]  shamt;
    logic        imm_sel;
    logic        illegal_op;

    int   checks = 0;
    int   errors = 0;
    exp_t sb[$];
    logic sticky_m;

    imm_operand_gen #(.DATA_W(16)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (flush),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .imm_ext    (imm_ext),
        .shamt      (shamt),
        .imm_sel    (imm_sel),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic exp_t model(input logic [15:0] w);
        exp_t e;
        e     = '0;
        e.sh  = w[2:0];
        case (w[15:12])
            4'h1, 4'h6, 4'h7, 4'h8: e.imm = {{10{w[5]}}, w[5:0]};
            4'h2, 4'h3:             e.imm = {10'b0, w[5:0]};
            4'h4, 4'h5:             e.sel = 1'b1;
            4'h9:                   e.imm = {w[7:0], 8'h00};
            4'h0:                   e.imm = 16'h0000;
            default:                e.ill = ILL_EN;
        endcase
        return e;
    endfunction

    task automatic push(input logic [15:0] w);
        exp_t e;
        e        = model(w);
        sticky_m = sticky_m | e.ill;
        e.ill    = sticky_m;
        sb.push_back(e);
    endtask

    // One cycle of stimulus, entered and left just after a rising edge
    task automatic drive(input logic v, input logic [15:0] w, input logic ordy, input logic exp_rdy);
        chk("in_ready", in_ready, exp_rdy);
        in_valid  = v;
        instr     = w;
        out_ready = ordy;
        if (v && exp_rdy && !flush && rst_n) push(w);
        @(posedge clk);
        #1;
    endtask

    // Delivered beats are compared against the scoreboard head
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $error("FAIL unexpected_beat observed=%0h expected=none", imm_ext);
            end else begin
                exp_t e;
                e = sb.pop_front();
                chk("beat_imm_ext", imm_ext, e.imm);
                chk("beat_shamt", shamt, e.sh);
                chk("beat_imm_sel", imm_sel, e.sel);
                chk("beat_illegal", illegal_op, e.ill);
            end
        end
    end

    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        in_valid  = 1'b0;
        instr     = '0;
        out_ready = 1'b0;
        sticky_m  = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_in_ready", in_ready, 1);
        chk("rst_imm_ext", imm_ext, 0);
        chk("rst_shamt", shamt, 0);
        chk("rst_imm_sel", imm_sel, 0);
        chk("rst_illegal", illegal_op, 0);
        rst_n = 1'b1;

        // ADDI with negative imm6, one-cycle latency
        drive(1'b1, 16'h103F, 1'b1, 1'b1);
        chk("t1_out_valid", out_valid, 1);
        chk("t1_imm_ext", imm_ext, 16'hFFFF);
        chk("t1_imm_sel", imm_sel, 0);
        drive(1'b0, 16'h0000, 1'b1, 1'b1);
        chk("t1_drain", out_valid, 0);

        // Back-to-back ORI, SLL, LUI
        drive(1'b1, 16'h3020, 1'b1, 1'b1);
        chk("t2_ori_imm", imm_ext, 16'h0020);
        drive(1'b1, 16'h4005, 1'b1, 1'b1);
        chk("t2_sll_shamt", shamt, 5);
        chk("t2_sll_sel", imm_sel, 1);
        drive(1'b1, 16'h90A5, 1'b1, 1'b1);
        chk("t2_lui_imm", imm_ext, 16'hA500);
        chk("t2_lui_sel", imm_sel, 0);
        drive(1'b0, 16'h0000, 1'b1, 1'b1);

        // Every opcode once with random low bits
        for (int op = 0; op < 16; op++) begin
            logic [15:0] w;
            w = {4'(op), 12'($urandom)};
            drive(1'b1, w, 1'b1, 1'b1);
        end
        drive(1'b0, 16'h0000, 1'b1, 1'b1);
        chk("sweep_drain", out_valid, 0);

        // Back-pressure fills the skid, then releases in order
        drive(1'b1, 16'h1001, 1'b0, 1'b1);
        drive(1'b1, 16'h1002, 1'b0, 1'b1);
        drive(1'b1, 16'h1003, 1'b0, 1'b0);
        chk("t3_hold_valid", out_valid, 1);
        chk("t3_hold_imm", imm_ext, 16'h0001);
        drive(1'b1, 16'h1003, 1'b0, 1'b0);
        chk("t3_hold_imm2", imm_ext, 16'h0001);
        drive(1'b1, 16'h1003, 1'b1, 1'b0);
        chk("t3_skid_out", imm_ext, 16'h0002);
        drive(1'b1, 16'h1003, 1'b1, 1'b1);
        chk("t3_third_out", imm_ext, 16'h0003);
        drive(1'b0, 16'h0000, 1'b1, 1'b1);
        chk("t3_drain", out_valid, 0);

        // Flush from SKID, then flush dropping a same-cycle valid
        drive(1'b1, 16'h1011, 1'b0, 1'b1);
        drive(1'b1, 16'h1012, 1'b0, 1'b1);
        flush = 1'b1;
        sb.delete();
        sticky_m = 1'b0;
        drive(1'b1, 16'h1013, 1'b0, 1'b0);
        flush = 1'b0;
        chk("t4_flush_valid", out_valid, 0);
        flush = 1'b1;
        drive(1'b1, 16'h1014, 1'b1, 1'b1);
        flush = 1'b0;
        chk("t4_drop_valid", out_valid, 0);
        drive(1'b0, 16'h0000, 1'b1, 1'b1);
        chk("t4_still_empty", out_valid, 0);

        // Illegal opcode and sticky flag
        drive(1'b1, 16'hB123, 1'b1, 1'b1);
        chk("t5_illegal", illegal_op, 32'(ILL_EN));
        chk("t5_imm_zero", imm_ext, 0);
        drive(1'b1, 16'h1001, 1'b1, 1'b1);
        drive(1'b1, 16'h4002, 1'b1, 1'b1);
        drive(1'b0, 16'h0000, 1'b1, 1'b1);
        chk("t5_sticky_idle", illegal_op, 32'(ILL_EN));
        flush = 1'b1;
        sb.delete();
        sticky_m = 1'b0;
        drive(1'b0, 16'h0000, 1'b1, 1'b1);
        flush = 1'b0;
        chk("t5_flush_clear", illegal_op, 0);

        // Reset while in SKID
        drive(1'b1, 16'h1021, 1'b0, 1'b1);
        drive(1'b1, 16'h1022, 1'b0, 1'b1);
        rst_n = 1'b0;
        sb.delete();
        sticky_m = 1'b0;
        drive(1'b1, 16'h1023, 1'b0, 1'b0);
        chk("t6_out_valid", out_valid, 0);
        chk("t6_imm_ext", imm_ext, 0);
        chk("t6_shamt", shamt, 0);
        chk("t6_imm_sel", imm_sel, 0);
        chk("t6_illegal", illegal_op, 0);
        rst_n = 1'b1;
        drive(1'b0, 16'h0000, 1'b1, 1'b1);
        chk("t6_no_pulse", out_valid, 0);
        drive(1'b0, 16'h0000, 1'b1, 1'b1);

        chk("sb_empty", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/imm_operand_gen.md
# imm_operand_gen

ID-stage immediate generator and pipeline register that produces the EX-stage immediate mux operands. Decodes each 16-bit instruction into a 16-bit extended immediate, a 3-bit shift amount and the operand select, then registers them into the ID/EX boundary. Uses a valid/ready handshake with a one-entry skid buffer so `in_ready` is driven from a flop. Sits between the IF/ID register and the EX-stage operand mux.

## Interface
- `DATA_W`, 16, width of instruction word and extended immediate (fixed to 16; parameter documents intent only).
- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: synchronous, active-low reset.
- `flush` input 1: squash all held and incoming instructions (branch taken).
- `in_valid` input 1: `instr` is valid.
- `in_ready` output 1: block accepts `instr` this cycle; registered.
- `instr` input 16: `[15:12]` opcode, `[11:9]` rs, `[8:6]` rt, `[5:3]` rd, `[5:0]` imm6, `[7:0]` imm8, `[2:0]` shamt.
- `out_valid` output 1: operand outputs valid.
- `out_ready` input 1: EX stage consumes outputs this cycle.
- `imm_ext` output 16: extended immediate (mux wide input).
- `shamt` output 3: shift amount (mux narrow input).
- `imm_sel` output 1: 1 = EX selects `shamt` (zero-extended), 0 = `imm_ext`.
- `illegal_op` output 1: see Configuration.

## Operation
- Decode by opcode:
  - 0x0 R-type: `imm_ext`=0, `imm_sel`=0.
  - 0x1 ADDI, 0x6 LW, 0x7 SW, 0x8 BEQ: `imm_ext` = sign-extend imm6.
  - 0x2 ANDI, 0x3 ORI: `imm_ext` = zero-extend imm6.
  - 0x4 SLL, 0x5 SRL: `imm_sel`=1, `shamt`=`instr[2:0]`, `imm_ext`=0.
  - 0x9 LUI: `imm_ext` = `{imm8, 8'h00}`.
  - 0xA–0xF: illegal.
- `shamt` is always `instr[2:0]` for non-shift opcodes (don't-care to EX); `imm_sel`=0 for those.
- Accept when `in_valid && in_ready && !flush`.
- States:
  - EMPTY: `out_valid`=0, skid empty.
  - FULL: output register valid, skid empty.
  - SKID: output register and skid both valid; `in_ready`=0.
- Transitions:
  - EMPTY + accept -> FULL.
  - FULL + accept + `out_ready` -> FULL, new word.
  - FULL + accept + !`out_ready` -> SKID, accepted word stored in skid.
  - FULL + !accept + `out_ready` -> EMPTY.
  - SKID + `out_ready` -> FULL, skid moved to output.
  - SKID + !`out_ready` -> hold.
- `flush`, from any state -> EMPTY next cycle. Same-cycle `in_valid` is dropped. `flush` has priority over all handshakes.
- Decoded output fields are held stable while `out_valid && !out_ready`.

## Timing
- Latency: instruction accepted in cycle N appears on outputs in cycle N+1 when the path is FULL/EMPTY-clear.
- Throughput: 1 instruction/cycle while `out_ready`=1.
- `in_ready` = !(next state is SKID), registered; deasserts the cycle after the skid fills.
- Reset (`rst_n`=0 at edge): state EMPTY, `out_valid`=0, `imm_ext`=0, `shamt`=0, `imm_sel`=0, `illegal_op`=0, `in_ready`=1 after the edge. Inputs are ignored while `rst_n`=0.
- Reset mid-transfer discards both held words; no output pulse follows.

## Configuration
- `IMM_ILLEGAL_FLAG_EN` defined:
  - Opcodes 0xA–0xF produce `imm_ext`=0, `imm_sel`=0, and `illegal_op`=1 for the same output beat.
  - Once set, `illegal_op` is sticky until reset or `flush`.
- Not defined:
  - `illegal_op` tied 0.
  - Opcodes 0xA–0xF are decoded as R-type NOPs (`imm_ext`=0, `imm_sel`=0).

## Test plan
- Reset, then ADDI `instr`=0x103F, `out_ready`=1 -> next cycle `out_valid`=1, `imm_ext`=0xFFFF, `imm_sel`=0.
- ORI 0x3020, then SLL 0x4005, then LUI 0x90A5, back-to-back -> outputs 0x0020/sel0, then shamt 5/sel1, then 0xA500/sel0; one per cycle.
- Hold `out_ready`=0 for 3 cycles while streaming ADDI 1, 2, 3 -> `in_ready` drops after the second accept; outputs stay at ADDI 1. Release -> ADDI 1, 2, 3 delivered in order, none lost.
- In SKID state assert `flush` with `in_valid`=1 -> next cycle `out_valid`=0, `in_ready`=1; the flushed words never appear.
- With `IMM_ILLEGAL_FLAG_EN`, send `instr`=0xB123 -> `illegal_op`=1 and stays 1 through later valid ops until `flush`. Without the macro -> `illegal_op`=0, `imm_ext`=0.
- Pull `rst_n` low for one cycle during SKID state -> all outputs 0 and state EMPTY next cycle.
